cpu_clk_ctrl: RTL

CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

---
 rtl/cpu_clk_pkg.sv | 15 +
 rtl/sync_edge.sv | 48 ++++
 rtl/cpu_clk_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cpu_clk_pkg.sv
// Shared state encodings and default tick periods for the CPU clock controller.
// Constants only; no timing or flow-control behaviour of its own.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_STOP = 2'b11
    } state_t;

    localparam int unsigned FAST_DIV_DEF = 4;
    localparam int unsigned SLOW_DIV_DEF = 50_000_000;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for one asynchronous level, with an optional registered rising-edge pulse.
// Latency: sync 2 clk, rise 3 clk after the first sampling edge; no backpressure (free-running).
module sync_edge #(
    parameter bit EDGE_EN = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic sync,
    output logic rise
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= level;
            sync <= meta;
        end
    end

    generate
        if (EDGE_EN) begin : g_edge
            logic       dly;
            logic [2:0] prime;

            // prime blocks the edge until dly holds a real post-reset sample,
            // so a level already high at reset release never looks like an edge
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dly   <= 1'b0;
                    prime <= 3'b000;
                    rise  <= 1'b0;
                end else begin
                    dly   <= sync;
                    prime <= {prime[1:0], 1'b1};
                    rise  <= sync & ~dly & prime[2];
                end
            end
        end else begin : g_no_edge
            assign rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU tick generator: free-running divided ticks (fast/slow), single steps, halt with acknowledge.
// Latency: step edge to cpu_en 4 clk, run to first tick 6 clk; no backpressure, ticks are never stalled.
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int unsigned FAST_DIV = FAST_DIV_DEF,
    parameter int unsigned SLOW_DIV = SLOW_DIV_DEF,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             slow,
    input  logic             step,
    input  logic             halt_req,
    input  logic             clr_cnt,
    output logic             cpu_en,
    output logic             halt_ack,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);

    // Asserts immediately, releases two clk edges after rst rises.
    logic [1:0] rst_pipe;
    logic       rst_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_sync = rst_pipe[1];

    logic run_s, slow_s, step_s, halt_s;
    logic run_rise, slow_rise, step_rise, halt_rise;
    logic unused_rise;

    sync_edge #(.EDGE_EN(1'b0)) u_run  (.clk(clk), .rst(rst_sync), .level(run),      .sync(run_s),  .rise(run_rise));
    sync_edge #(.EDGE_EN(1'b0)) u_slow (.clk(clk), .rst(rst_sync), .level(slow),     .sync(slow_s), .rise(slow_rise));
    sync_edge #(.EDGE_EN(1'b1)) u_step (.clk(clk), .rst(rst_sync), .level(step),     .sync(step_s), .rise(step_rise));
    sync_edge #(.EDGE_EN(1'b0)) u_halt (.clk(clk), .rst(rst_sync), .level(halt_req), .sync(halt_s), .rise(halt_rise));

    assign unused_rise = run_rise | slow_rise | halt_rise | step_s;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] div_q, div_nxt;
    logic             slow_sel_q, slow_sel_nxt;
    logic             en_nxt;
    logic [CNT_W-1:0] last_cur, last_nxt;

    assign last_cur = slow_sel_q   ? SLOW_LAST : FAST_LAST;
    assign last_nxt = slow_sel_nxt ? SLOW_LAST : FAST_LAST;

    always_comb begin
        state_nxt    = state_q;
        div_nxt      = '0;
        slow_sel_nxt = slow_sel_q;
        en_nxt       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!halt_s) begin
                    if (run_s) begin
                        state_nxt    = ST_RUN;
                        slow_sel_nxt = slow_s;
                    end else if (step_rise) begin
                        state_nxt = ST_STEP;
                    end
                end
            end
            ST_RUN: begin
                if (halt_s || !run_s) begin
                    state_nxt = ST_STOP;
                end else if (div_q == last_cur) begin
                    // period changes only at a wrap so no tick is shortened or doubled
                    slow_sel_nxt = slow_s;
                end else begin
                    div_nxt = div_q + CNT_W'(1);
                end
            end
            ST_STEP: state_nxt = ST_IDLE;
            ST_STOP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        // cpu_en is registered, so it is computed for the cycle being entered
        en_nxt = (state_nxt == ST_STEP) ||
                 ((state_nxt == ST_RUN) && (div_nxt == last_nxt));
    end

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            slow_sel_q <= 1'b0;
            cpu_en     <= 1'b0;
            halt_ack   <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            div_q      <= div_nxt;
            slow_sel_q <= slow_sel_nxt;
            cpu_en     <= en_nxt;
            halt_ack   <= (state_nxt == ST_STOP);
        end
    end

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            cycle_cnt <= '0;
        end else if (clr_cnt) begin
            cycle_cnt <= '0;
        end else if (cpu_en) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

    assign state = state_q;

endmodule
